// File: rtl/pkg_mult.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package pkg_mult;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = $clog2(DW);

  typedef logic [DW-1:0]   val_t;
  typedef logic [2*DW-1:0] multiplier_t;
  typedef logic [CW-1:0]   count_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mult_step_cnt.sv
// Clearable, enabled step counter; saturates at DW-1 and flags it on tc.
module mult_step_cnt
  import pkg_mult::*;
#(
  parameter int unsigned DW = pkg_mult::DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  output logic [$clog2(DW)-1:0]  cnt,
  output logic                   tc
);

  localparam int unsigned CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mult_ctrl.sv
// Sequencing controller for the shift-and-add multiplier: load, DW shift/add steps, hold done.
module mult_ctrl
  import pkg_mult::*;
#(
  parameter int unsigned DW = pkg_mult::DW
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_ack,
  input  logic                   i_lsb,
  output logic                   o_load,
  output logic                   o_shift,
  output logic                   o_add,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [$clog2(DW)-1:0]  o_cnt
);

  state_e state, state_nxt;
  logic   tc;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Enables decode from the registered state only; o_add is the lone path from an input.
  always_comb begin
    state_nxt = state;
    o_load    = 1'b0;
    o_shift   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) state_nxt = LOAD;
      end
      LOAD: begin
        o_load    = 1'b1;
        o_busy    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        o_shift = 1'b1;
        o_busy  = 1'b1;
        if (tc) state_nxt = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start)    state_nxt = LOAD;
        else if (i_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    o_add = o_shift & i_lsb;
  end

  mult_step_cnt #(
    .DW (DW)
  ) u_step_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (o_load),
    .en  (o_shift),
    .cnt (o_cnt),
    .tc  (tc)
  );

endmodule
